// File: rtl/modacc.sv
// Streaming modular accumulator: sums one in_last-delimited frame of coefficients mod q
// and presents the sum, beat count and overflow flag on a held output handshake.
module modacc #(
   parameter int unsigned  LOGQ   = 64,
   parameter int unsigned  LOGQH  = 47,
   parameter int unsigned  MAXLEN = 1024,
   localparam int unsigned CNTW   = $clog2(MAXLEN + 1)
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic [LOGQH-1:0] qH,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [LOGQ-1:0]  in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [LOGQ-1:0]  out_data,
   output logic [CNTW-1:0]  out_count,
   output logic             out_ovf
);

   typedef enum logic [1:0] {StIdle, StAcc, StHold} state_e;

   state_e          state;
   logic [LOGQ-1:0] acc;
   logic [LOGQ-1:0] qreg;
   logic [CNTW-1:0] cnt;
   logic            ovf;

   logic            beat;
   logic [LOGQ-1:0] q_new;
   logic [LOGQ-1:0] q_use;
   logic [LOGQ-1:0] acc_src;
   logic [LOGQ:0]   sum;
   logic [LOGQ:0]   dif;
   logic [LOGQ-1:0] result;
   logic [CNTW-1:0] cnt_nxt;
   logic            ovf_nxt;
   logic            cnt_full;

   assign in_ready = (state != StHold);
   assign beat     = in_valid & in_ready;
   assign cnt_full = (cnt == CNTW'(MAXLEN));

   always_comb begin
      q_new   = {qH, {(LOGQ - LOGQH - 1){1'b0}}, 1'b1};
      acc_src = '0;
      q_use   = q_new;
      cnt_nxt = CNTW'(1);
      ovf_nxt = 1'b0;
      // First beat of a frame starts from zero with a freshly sampled modulus.
      if (state == StAcc) begin
         acc_src = acc;
         q_use   = qreg;
         cnt_nxt = cnt_full ? cnt : cnt + CNTW'(1);
         ovf_nxt = ovf | cnt_full;
      end
      sum    = {1'b0, acc_src} + {1'b0, in_data};
      dif    = sum - {1'b0, q_use};
      result = dif[LOGQ] ? sum[LOGQ-1:0] : dif[LOGQ-1:0];
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state     <= StIdle;
         acc       <= '0;
         qreg      <= '0;
         cnt       <= '0;
         ovf       <= 1'b0;
         out_data  <= '0;
         out_count <= '0;
         out_ovf   <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         case (state)
            StIdle, StAcc: begin
               if (beat) begin
                  qreg <= q_use;
                  acc  <= result;
                  cnt  <= cnt_nxt;
                  ovf  <= ovf_nxt;
                  if (in_last) begin
                     out_data  <= result;
                     out_count <= cnt_nxt;
                     out_ovf   <= ovf_nxt;
                     out_valid <= 1'b1;
                     state     <= StHold;
                  end else begin
                     state <= StAcc;
                  end
               end
            end
            StHold: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= StIdle;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_modacc.sv
// Bench for modacc: directed frames plus randomized frames, checked through an
// expected-result queue against a plain-arithmetic modular-sum model.
module tb_modacc;

   localparam int unsigned LOGQ   = 64;
   localparam int unsigned LOGQH  = 47;
   localparam int unsigned MAXLEN = 4;
   localparam int unsigned CNTW   = $clog2(MAXLEN + 1);
   localparam logic [LOGQH-1:0] QH = 47'h400008C00000;
   localparam logic [LOGQ-1:0]  Q  = 64'h8000118000000001;

   typedef struct {
      logic [63:0] data;
      int unsigned count;
      logic        ovf;
   } exp_t;

   logic             clk;
   logic             rstn;
   logic [LOGQH-1:0] qH;
   logic             in_valid;
   logic             in_ready;
   logic [LOGQ-1:0]  in_data;
   logic             in_last;
   logic             out_valid;
   logic             out_ready;
   logic [LOGQ-1:0]  out_data;
   logic [CNTW-1:0]  out_count;
   logic             out_ovf;

   int unsigned total = 0;
   int unsigned bad = 0;
   int unsigned frames_in = 0;
   int unsigned frames_out = 0;
   int unsigned rdy_mode = 0;  // 0: always ready, 1: never ready, 2: random

   exp_t        exp_q[$];
   logic [64:0] fsum = '0;
   int unsigned fn = 0;

   modacc #(
      .LOGQ  (LOGQ),
      .LOGQH (LOGQH),
      .MAXLEN(MAXLEN)
   ) dut (
      .clk      (clk),
      .rstn     (rstn),
      .qH       (qH),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .in_last  (in_last),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (out_data),
      .out_count(out_count),
      .out_ovf  (out_ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // out_ready is owned by this process only; inputs change 2 time units after the edge.
   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #2;
         case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'b0;
            default: out_ready = ($urandom_range(0, 3) != 0);
         endcase
      end
   end

   // Monitor: a handshake is due at the next rising edge when both are high here.
   always @(negedge clk) begin
      if (rstn && out_valid && out_ready) begin
         exp_t e;
         frames_out++;
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_output: got data %h with no frame outstanding", out_data);
         end else begin
            e = exp_q.pop_front();
            check("out_data", out_data, e.data);
            check("out_count", 64'(out_count), 64'(e.count));
            check("out_ovf", 64'(out_ovf), 64'(e.ovf));
         end
      end
   end

   task automatic idle(input int unsigned n);
      in_valid = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Drive one beat until accepted, then update the frame model.
   task automatic send_beat(input logic [63:0] d, input logic last);
      int unsigned waits = 0;
      logic        took;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      forever begin
         @(negedge clk);
         took = in_ready;
         @(posedge clk);
         #1;
         if (took) break;
         waits++;
         if (waits > 200) begin
            total++;
            bad++;
            $display("FAIL beat_timeout: got in_ready=0 for %0d cycles, expected acceptance", waits);
            break;
         end
      end
      in_valid = 1'b0;
      if (fn == 0) fsum = '0;
      fsum = (fsum + {1'b0, d}) % {1'b0, Q};
      fn++;
      if (last) begin
         exp_t e;
         e.data  = fsum[63:0];
         e.count = (fn > MAXLEN) ? MAXLEN : fn;
         e.ovf   = (fn > MAXLEN);
         exp_q.push_back(e);
         frames_in++;
         fn = 0;
      end
   endtask

   function automatic logic [63:0] rand_val();
      logic [63:0] r;
      int unsigned sel;
      r   = {$urandom, $urandom};
      sel = $urandom_range(0, 15);
      if (sel == 0) return 64'h0;
      if (sel < 3) return Q - 64'h1;
      return r % Q;
   endfunction

   initial begin
      logic [63:0] r64;
      int unsigned len;
      int unsigned guard;
      rstn     = 1'b0;
      qH       = QH;
      in_valid = 1'b0;
      in_data  = '0;
      in_last  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", 64'(out_valid), 64'h0);
      check("rst_in_ready", 64'(in_ready), 64'h1);
      check("rst_out_data", out_data, 64'h0);
      check("rst_out_count", 64'(out_count), 64'h0);
      check("rst_out_ovf", 64'(out_ovf), 64'h0);
      rstn = 1'b1;
      idle(2);

      // Basic frame with one-cycle result latency
      send_beat(64'h010000000000000A, 1'b0);
      send_beat(64'h1000000000000005, 1'b0);
      send_beat(64'h1, 1'b1);
      check("basic_valid", 64'(out_valid), 64'h1);
      check("basic_data", out_data, 64'h1100000000000010);
      check("basic_count", 64'(out_count), 64'd3);
      idle(2);

      send_beat(64'h8000118000000000, 1'b0);
      send_beat(64'h2, 1'b1);
      check("wrap_data", out_data, 64'h1);
      idle(1);
      send_beat(64'h8000118000000000, 1'b0);
      send_beat(64'h1, 1'b1);
      check("exact_q_data", out_data, 64'h0);
      idle(2);

      // Backpressure: result held while a pending beat waits upstream
      rdy_mode = 1;
      send_beat(64'h5, 1'b0);
      send_beat(64'h6, 1'b1);
      in_valid = 1'b1;
      in_data  = 64'h7;
      in_last  = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_out_valid", 64'(out_valid), 64'h1);
         check("bp_in_ready", 64'(in_ready), 64'h0);
         check("bp_out_data", out_data, 64'hB);
         check("bp_out_count", 64'(out_count), 64'd2);
         @(posedge clk);
         #1;
      end
      rdy_mode = 0;
      send_beat(64'h7, 1'b1);
      check("bp_next_data", out_data, 64'h7);
      check("bp_next_count", 64'(out_count), 64'd1);
      idle(2);

      // Overflow past MAXLEN, then a clean frame
      for (int i = 0; i < 6; i++) send_beat(64'h1, i == 5);
      check("ovf_flag", 64'(out_ovf), 64'h1);
      check("ovf_count", 64'(out_count), 64'd4);
      check("ovf_data", out_data, 64'h6);
      send_beat(64'h3, 1'b0);
      send_beat(64'h4, 1'b1);
      check("post_ovf_flag", 64'(out_ovf), 64'h0);
      check("post_ovf_count", 64'(out_count), 64'd2);
      idle(2);

      // Reset mid-frame discards the partial sum
      send_beat(64'h3, 1'b0);
      send_beat(64'h4, 1'b0);
      rstn = 1'b0;
      @(posedge clk);
      #1;
      rstn = 1'b1;
      fn   = 0;
      check("midrst_out_valid", 64'(out_valid), 64'h0);
      check("midrst_in_ready", 64'(in_ready), 64'h1);
      check("midrst_out_data", out_data, 64'h0);
      send_beat(64'h9, 1'b1);
      check("midrst_next_data", out_data, 64'h9);
      check("midrst_next_count", 64'(out_count), 64'd1);
      idle(2);

      // Randomized frames; qH is scrambled mid-frame and must be ignored
      rdy_mode = 2;
      for (int f = 0; f < 1000; f++) begin
         len = $urandom_range(1, 16);
         for (int b = 0; b < int'(len); b++) begin
            idle($urandom_range(0, 2));
            r64 = {$urandom, $urandom};
            qH  = (b == 0) ? QH : r64[LOGQH-1:0];
            send_beat(rand_val(), b == int'(len) - 1);
         end
      end
      qH       = QH;
      rdy_mode = 0;

      guard = 0;
      while (exp_q.size() != 0 && guard < 1000) begin
         @(posedge clk);
         guard++;
      end
      idle(3);
      check("queue_drained", 64'(exp_q.size()), 64'h0);
      check("frame_count", 64'(frames_out), 64'(frames_in));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/modacc.md
Name: modacc

Overview:
- Streaming modular accumulator that sums a frame of coefficients mod q.
- Sits directly downstream of the modadd/modmul pipelines and consumes their reduced outputs, e.g. for inner products or coefficient sums.
- q has the NTT-friendly form used by modadd: q = {qH, (LOGQ-LOGQH-1) zero bits, 1'b1}.
- Uses valid/ready handshakes on both sides, with a frame delimited by in_last.

Parameters:
- LOGQ, 64: modulus and data width.
- LOGQH, 47: width of the qH field of the modulus.
- MAXLEN, 1024: maximum frame length before the overflow flag is set.
- CNTW, $clog2(MAXLEN+1): width of the beat counter (localparam).

Ports:
- clk  in  1  clock, all state updates on its rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- qH  in  LOGQH  high part of the modulus; sampled on the first beat of each frame.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- in_data  in  LOGQ  coefficient; must be < q.
- in_last  in  1  marks the final beat of the frame.
- out_valid  out  1  frame result valid.
- out_ready  in  1  consumer accepts the result.
- out_data  out  LOGQ  frame sum mod q.
- out_count  out  CNTW  beats in the frame, saturating at MAXLEN.
- out_ovf  out  1  frame exceeded MAXLEN beats.

Behaviour:
- Reset (rstn=0, asynchronous):
  - state=IDLE.
  - acc, qreg, cnt, out_data, out_count = 0.
  - out_valid=0, out_ovf=0.
  - in_ready = 1 (combinational: state != HOLD).
- Beat: in_valid & in_ready on a rising edge.
- Modular add per beat:
  - S = acc_src + in_data, computed LOGQ+1 bits wide.
  - D = S - q_use, computed LOGQ+1 bits wide.
  - Result = D[LOGQ]==0 ? D[LOGQ-1:0] : S[LOGQ-1:0].
  - Single cycle, no internal pipeline.
- State IDLE:
  - On a beat: acc_src=0 and q_use={qH,0..,1}; qreg<=q_use; acc<=result; cnt<=1; ovf<=0.
  - If in_last on that beat -> HOLD, else -> ACC.
- State ACC:
  - On a beat: acc_src=acc, q_use=qreg; acc<=result.
  - cnt<=cnt+1, saturating at MAXLEN. If cnt==MAXLEN before increment, set ovf sticky for the frame.
  - If in_last -> HOLD. No beat -> hold all state.
- Entry to HOLD (on the last-beat edge):
  - out_data<=final result; out_count<=final cnt; out_ovf<=final ovf; out_valid<=1.
  - Latency: out_valid is high in the cycle after the last beat is accepted.
- State HOLD:
  - in_ready=0.
  - out_* outputs stable until out_valid & out_ready.
  - On that edge: out_valid<=0, state -> IDLE; in_ready=1 in the next cycle.
  - out_data, out_count, out_ovf retain their values after handoff until the next frame completes.
- Single-beat frame: IDLE -> HOLD directly; out_data = in_data (already < q).
- in_data >= q is a protocol violation; the result is unspecified and is not checked.
- qH changes mid-frame are ignored; qreg is used for all beats after the first.
- Reset mid-frame or during HOLD: the partial frame is discarded, no output is produced, and the block returns to reset state.
- in_valid while in HOLD: no beat; upstream must hold its data.

Test Plan:
All scenarios use qH=47'h400008C00000, so q=64'h8000118000000001.
- Basic frame: beats 64'h010000000000000A, 64'h1000000000000005, 64'h1 (last) -> one cycle later out_valid=1, out_data=64'h1100000000000010, out_count=3, out_ovf=0.
- Wrap-around: beats 64'h8000118000000000, 64'h2 (last) -> out_data=64'h1. Exact-q case: beats 64'h8000118000000000, 64'h1 (last) -> out_data=0.
- Backpressure: out_ready=0 for 5 cycles after a result -> out_* stable and in_ready=0; a held in_valid beat is not accepted. After out_ready=1, that beat 64'h7 (last) gives out_data=7, out_count=1.
- Overflow with MAXLEN=4: 6 beats of 64'h1 -> out_data=6, out_count=4, out_ovf=1. The next 2-beat frame reports out_ovf=0, out_count=2.
- Reset mid-frame: 2 beats accepted, then rstn low for 1 cycle -> out_valid=0 and in_ready=1. A following single-beat frame 64'h9 gives out_data=9, out_count=1.
- Randomized: 1000 frames of random length 1..16, values < q, random in_valid/out_ready gaps -> matches the reference model; no beat lost or duplicated.
